// File: rtl/instr_loader_pkg.sv
// ----------------------------------------------------------------------------
// instr_loader_pkg
//   Shared definitions for the instruction memory loader:
//     - MIPS opcode/function constants used by the encoder
//     - bit positions of each instruction field inside a 32-bit word
//     - loader FSM state encoding
//     - packed field tuple and the combinational encoder function
// ----------------------------------------------------------------------------
package instr_loader_pkg;

    // Opcode forced onto every R-type word, and the ADD function code.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] FUNC_ADD = 6'h20;

    // Field format selector carried by fmt_i.
    localparam logic FMT_R = 1'b0;
    localparam logic FMT_I = 1'b1;

    // Least-significant bit of each field within the instruction word.
    localparam int OP_LSB    = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNC_LSB  = 0;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_e;

    typedef struct packed {
        logic        fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] imm;
    } instr_fields_t;

    // Builds the instruction word. Fields that do not belong to the selected
    // format are ignored; for R-type the opcode input is ignored as well and
    // OP_RTYPE is used instead.
    function automatic logic [31:0] encode_instr(instr_fields_t f);
        logic [31:0] w;
        w = '0;
        if (f.fmt == FMT_R) begin
            w[OP_LSB +: 6]    = OP_RTYPE;
            w[RS_LSB +: 5]    = f.rs;
            w[RT_LSB +: 5]    = f.rt;
            w[RD_LSB +: 5]    = f.rd;
            w[SHAMT_LSB +: 5] = f.shamt;
            w[FUNC_LSB +: 6]  = f.func;
        end else begin
            w[OP_LSB +: 6]    = f.op;
            w[RS_LSB +: 5]    = f.rs;
            w[RT_LSB +: 5]    = f.rt;
            w[IMM_LSB +: 16]  = f.imm;
        end
        return w;
    endfunction

endpackage

// File: rtl/instr_loader_fifo.sv
// ----------------------------------------------------------------------------
// instr_loader_fifo
//   Synchronous first-word-fall-through FIFO holding encoded instruction words
//   between the field-input side and the memory write port.
//
//   Ports
//     clk_i        clock, posedge
//     rst_i        synchronous active-high reset, empties the FIFO
//     clr_i        synchronous clear, same effect as reset (new load session)
//     push_i       write wdata_i; ignored when full
//     wdata_i      word to store
//     pop_i        discard head word; ignored when empty
//     rdata_o      head word (valid while empty_o is low)
//     occupancy_o  number of stored words, 0..DEPTH
//     full_o       occupancy_o == DEPTH
//     empty_o      occupancy_o == 0
//
//   DEPTH must be a power of two so that the pointers wrap naturally.
// ----------------------------------------------------------------------------
module instr_loader_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [OCC_W-1:0] occupancy_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o      = (occ_q == OCC_W'(DEPTH));
    assign empty_o     = (occ_q == '0);
    assign occupancy_o = occ_q;
    assign rdata_o     = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // A simultaneous push and pop leaves the occupancy unchanged.
            case ({push_ok, pop_ok})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage needs no reset: a word is only ever read after being written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//   Assembles MIPS instruction words from field tuples and writes them into the
//   instruction memory at consecutive word addresses 0,1,2,... A small FIFO
//   decouples tuple acceptance from the registered memory write port.
//
//   Ports
//     clk_i, rst_i       clock (posedge) and synchronous active-high reset
//     start_i            begin a load session (honoured in IDLE and DONE)
//     in_valid_i         tuple valid
//     in_ready_o         tuple accepted when in_valid_i && in_ready_o at posedge
//     last_i             tuple is the final instruction of the program
//     fmt_i              0 = R-type, 1 = I-type
//     op_i, rs_i, rt_i, rd_i, shamt_i, func_i, imm_i   instruction fields
//     mem_we_o           memory write strobe, one cycle per word
//     mem_addr_o         word address of the write
//     mem_wdata_o        encoded instruction word
//     count_o            words written in this session
//     done_o             session complete, held until the next start_i
//     full_o             count_o == INSTR_NUM
//     checksum_o         XOR of words written this session (optional feature)
//     state_o            FSM state (debug visibility)
//
//   Handshake: a tuple transfers on a rising edge where in_valid_i and
//   in_ready_o are both high; the tuple fields and last_i must be stable while
//   in_valid_i is high. in_ready_o depends only on registered state.
//
//   Configuration macro: LOADER_CHECKSUM_EN. When defined, checksum_o holds the
//   running XOR of every word written in the current session; when undefined,
//   checksum_o is tied to zero and no checksum register exists.
// ----------------------------------------------------------------------------
module instr_mem_loader
    import instr_loader_pkg::*;
#(
    parameter int INSTR_NUM  = 256,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              last_i,
    input  logic              fmt_i,
    input  logic [5:0]        op_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        func_i,
    input  logic [15:0]       imm_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              full_o,
    output logic [31:0]       checksum_o,
    output logic [1:0]        state_o
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SUM_W = ADDR_W + 2;

    localparam logic [ADDR_W:0]  MAX_COUNT = (ADDR_W + 1)'(INSTR_NUM);
    localparam logic [SUM_W-1:0] MAX_SUM   = SUM_W'(INSTR_NUM);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    loader_state_e     state_q;
    logic              last_seen_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   count_d;
    logic              full_q;
    logic              done_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    // ------------------------------------------------------------------
    // FIFO and datapath signals
    // ------------------------------------------------------------------
    instr_fields_t     fields;
    logic [31:0]       enc_word;
    logic [31:0]       fifo_rdata;
    logic [OCC_W-1:0]  fifo_occ;
    logic              fifo_full;
    logic              fifo_empty;
    logic [SUM_W-1:0]  pending_total;
    logic              in_ready;
    logic              in_fire;
    logic              pop;
    logic              session_start;
    logic              load_done;

    // Encoder: purely combinational, the result is pushed on accept.
    always_comb begin
        fields.fmt   = fmt_i;
        fields.op    = op_i;
        fields.rs    = rs_i;
        fields.rt    = rt_i;
        fields.rd    = rd_i;
        fields.shamt = shamt_i;
        fields.func  = func_i;
        fields.imm   = imm_i;
    end

    assign enc_word = encode_instr(fields);

    // Words already written plus words still buffered. Keeping this below
    // INSTR_NUM before accepting means the memory can never overflow, so no
    // accepted word is ever dropped.
    assign pending_total = SUM_W'(count_q) + SUM_W'(fifo_occ);

    // A full FIFO refuses input even if a pop happens in the same cycle;
    // this keeps in_ready free of any same-cycle dependency on the drain.
    assign in_ready = (state_q == LOAD) && !last_seen_q && !fifo_full &&
                      (pending_total < MAX_SUM);
    assign in_fire  = in_valid_i && in_ready;

    assign pop           = (state_q == LOAD) && !fifo_empty;
    assign session_start = start_i && (state_q != LOAD);
    assign count_d       = count_q + 1'b1;

    // The session ends only after the final word has left the write register,
    // so done_o never rises while a memory write is still being presented.
    assign load_done = fifo_empty && !mem_we_q && (last_seen_q || full_q);

    instr_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (session_start),
        .push_i      (in_fire),
        .wdata_i     (enc_word),
        .pop_i       (pop),
        .rdata_o     (fifo_rdata),
        .occupancy_o (fifo_occ),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ------------------------------------------------------------------
    // FSM, write port and session counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            last_seen_q <= 1'b0;
            count_q     <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q     <= LOAD;
                        last_seen_q <= 1'b0;
                        count_q     <= '0;
                        full_q      <= 1'b0;
                        done_q      <= 1'b0;
                        mem_addr_q  <= '0;
                    end
                end
                LOAD: begin
                    if (in_fire && last_i) begin
                        last_seen_q <= 1'b1;
                    end
                    // The write address is the number of words written so far,
                    // so addresses are consecutive and never wrap.
                    if (pop) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= count_q[ADDR_W-1:0];
                        mem_wdata_q <= fifo_rdata;
                        count_q     <= count_d;
                        full_q      <= (count_d == MAX_COUNT);
                    end
                    if (load_done) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Optional running checksum of written words
    // ------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            checksum_q <= '0;
        end else if (session_start) begin
            checksum_q <= '0;
        end else if (pop) begin
            // Same edge that raises mem_we_o with this word.
            checksum_q <= checksum_q ^ fifo_rdata;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = 32'd0;
`endif

    assign in_ready_o  = in_ready;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign count_o     = count_q;
    assign done_o      = done_q;
    assign full_o      = full_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// ----------------------------------------------------------------------------
// tb_instr_mem_loader
//   Self-checking bench for instr_mem_loader: a table of hand-encoded field
//   tuples, random back-to-back streams, a capacity-limit stream and a
//   mid-session reset. Every accepted tuple pushes {address, word} onto an
//   expected queue; the write monitor pops and compares on each mem_we_o.
// ----------------------------------------------------------------------------
module tb_instr_mem_loader;

    localparam int INSTR_NUM  = 256;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic        fmt;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  func;
        logic [15:0] imm;
    } tuple_t;

    typedef struct packed {
        tuple_t      t;
        logic [31:0] exp_word;
    } vec_t;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic              clk;
    logic              rst_i;
    logic              start_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic              last_i;
    logic              fmt_i;
    logic [5:0]        op_i;
    logic [4:0]        rs_i;
    logic [4:0]        rt_i;
    logic [4:0]        rd_i;
    logic [4:0]        shamt_i;
    logic [5:0]        func_i;
    logic [15:0]       imm_i;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [ADDR_W:0]   count_o;
    logic              done_o;
    logic              full_o;
    logic [31:0]       checksum_o;
    logic [1:0]        dbg_state;

    instr_mem_loader #(
        .INSTR_NUM  (INSTR_NUM),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .last_i      (last_i),
        .fmt_i       (fmt_i),
        .op_i        (op_i),
        .rs_i        (rs_i),
        .rt_i        (rt_i),
        .rd_i        (rd_i),
        .shamt_i     (shamt_i),
        .func_i      (func_i),
        .imm_i       (imm_i),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .count_o     (count_o),
        .done_o      (done_o),
        .full_o      (full_o),
        .checksum_o  (checksum_o),
        .state_o     (dbg_state)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [39:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       csum_model;
    int                accepted;
    int                writes;
    int                first_wr_cycle;
    int                last_wr_cycle;
    logic [ADDR_W-1:0] last_wr_addr;
    int                checks = 0;
    int                errors = 0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Write monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [39:0] e;
        if (mem_we_o === 1'b1) begin
            writes++;
            last_wr_addr  = mem_addr_o;
            last_wr_cycle = cyc;
            if (first_wr_cycle < 0) first_wr_cycle = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %h, required no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr",  40'(mem_addr_o), 40'(e[39:32]));
                check("wr_data",  40'(mem_wdata_o), 40'(e[31:0]));
                check("wr_count", 40'(count_o), 40'(e[39:32]) + 40'd1);
            end
        end
        // Bench-side occupancy: words accepted but not yet written.
        if (in_ready_o === 1'b1) begin
            checks++;
            if ((accepted - writes) >= FIFO_DEPTH) begin
                errors++;
                $display("FAIL ready_while_full: in_ready_o=1 with %0d words buffered, required 0",
                         accepted - writes);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    function automatic vec_t mk(input logic fmt, input logic [5:0] op, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                input logic [5:0] fn, input logic [15:0] imm, input logic [31:0] w);
        vec_t v;
        v.t.fmt = fmt; v.t.op = op; v.t.rs = rs; v.t.rt = rt; v.t.rd = rd;
        v.t.shamt = sh; v.t.func = fn; v.t.imm = imm; v.exp_word = w;
        return v;
    endfunction

    function automatic logic [31:0] model_encode(input tuple_t t);
        if (t.fmt == 1'b0)
            return (32'(t.rs) << 21) | (32'(t.rt) << 16) | (32'(t.rd) << 11) |
                   (32'(t.shamt) << 6) | 32'(t.func);
        return (32'(t.op) << 26) | (32'(t.rs) << 21) | (32'(t.rt) << 16) | 32'(t.imm);
    endfunction

    function automatic tuple_t rand_tuple();
        tuple_t t;
        t.fmt   = 1'($urandom_range(0, 1));
        t.op    = 6'($urandom_range(0, 63));
        t.rs    = 5'($urandom_range(0, 31));
        t.rt    = 5'($urandom_range(0, 31));
        t.rd    = 5'($urandom_range(0, 31));
        t.shamt = 5'($urandom_range(0, 31));
        t.func  = 6'($urandom_range(0, 63));
        t.imm   = 16'($urandom_range(0, 65535));
        return t;
    endfunction

    task automatic drive_fields(input tuple_t t);
        fmt_i = t.fmt; op_i = t.op; rs_i = t.rs; rt_i = t.rt; rd_i = t.rd;
        shamt_i = t.shamt; func_i = t.func; imm_i = t.imm;
    endtask

    task automatic idle_inputs();
        in_valid_i = 1'b0;
        last_i     = 1'b0;
    endtask

    // Holds the tuple valid until accepted or the cycle budget runs out.
    // Inputs are left valid on return so consecutive calls stream back-to-back.
    task automatic send_tuple(input tuple_t t, input logic last, input logic [31:0] word,
                              input int budget, output bit ok);
        bit hit;
        drive_fields(t);
        last_i     = last;
        in_valid_i = 1'b1;
        ok         = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            hit = (in_ready_o === 1'b1);
            @(posedge clk);
            #1;
            if (hit) begin
                ok = 1'b1;
                exp_q.push_back({exp_addr, word});
                exp_addr++;
                accepted++;
                csum_model ^= word;
            end
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i        = 1'b0;
        exp_addr       = '0;
        csum_model     = '0;
        accepted       = 0;
        writes         = 0;
        first_wr_cycle = -1;
        last_wr_cycle  = -1;
        last_wr_addr   = '0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: done_o low after %0d cycles, required high", name, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_mem_we"},   40'(mem_we_o),    40'd0);
        check({tag, "_mem_addr"}, 40'(mem_addr_o),  40'd0);
        check({tag, "_mem_wdata"},40'(mem_wdata_o), 40'd0);
        check({tag, "_count"},    40'(count_o),     40'd0);
        check({tag, "_done"},     40'(done_o),      40'd0);
        check({tag, "_full"},     40'(full_o),      40'd0);
        check({tag, "_checksum"}, 40'(checksum_o),  40'd0);
        check({tag, "_in_ready"}, 40'(in_ready_o),  40'd0);
    endtask

    task automatic check_checksum(input string name);
`ifdef LOADER_CHECKSUM_EN
        check(name, 40'(checksum_o), 40'(csum_model));
`else
        check(name, 40'(checksum_o), 40'd0);
`endif
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    vec_t   vecs[8];
    tuple_t t;
    bit     ok;
    int     n_ok;

    initial begin
        // Table of hand-encoded tuples; fields irrelevant to the format are
        // scrambled below to show they do not leak into the word.
        vecs[0] = mk(1'b0, 6'h00, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 32'h00221820);
        vecs[1] = mk(1'b1, 6'h08, 5'd1,  5'd4,  5'd0,  5'd0,  6'h00, 16'hFFFF, 32'h2024FFFF);
        vecs[2] = mk(1'b0, 6'h3F, 5'd1,  5'd2,  5'd3,  5'd0,  6'h20, 16'h0000, 32'h00221820);
        vecs[3] = mk(1'b0, 6'h15, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'h0000, 32'h03FFFFFF);
        vecs[4] = mk(1'b1, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 32'hFC000000);
        vecs[5] = mk(1'b1, 6'h23, 5'd29, 5'd8,  5'd0,  5'd0,  6'h00, 16'h0004, 32'h8FA80004);
        vecs[6] = mk(1'b0, 6'h2A, 5'd0,  5'd9,  5'd10, 5'd2,  6'h00, 16'h0000, 32'h00095080);
        vecs[7] = mk(1'b1, 6'h0D, 5'd2,  5'd3,  5'd0,  5'd0,  6'h00, 16'h1234, 32'h34431234);

        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; last_i = 1'b0;
        drive_fields('0);
        exp_addr = '0; csum_model = '0; accepted = 0; writes = 0;
        first_wr_cycle = -1; last_wr_cycle = -1; last_wr_addr = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        check_reset_values("reset");

        // Single R-type ADD with last
        do_start();
        check("start_ready", 40'(in_ready_o), 40'd1);
        t = vecs[0].t;
        send_tuple(t, 1'b1, vecs[0].exp_word, 20, ok);
        check("t1_accept", 40'(ok), 40'd1);
        idle_inputs();
        wait_done("t1_done", 20);
        check("t1_count", 40'(count_o), 40'd1);
        check("t1_in_ready_after", 40'(in_ready_o), 40'd0);
        check("t1_full", 40'(full_o), 40'd0);
        check_checksum("t1_checksum");

        // Table session, back-to-back, last on the final entry
        do_start();
        check("tab_count_cleared", 40'(count_o), 40'd0);
        check("tab_done_cleared", 40'(done_o), 40'd0);
        n_ok = 0;
        for (int i = 0; i < 8; i++) begin
            t = vecs[i].t;
            if (t.fmt == 1'b0) t.imm = 16'($urandom_range(0, 65535));
            else begin
                t.rd    = 5'($urandom_range(0, 31));
                t.shamt = 5'($urandom_range(0, 31));
                t.func  = 6'($urandom_range(0, 63));
            end
            send_tuple(t, (i == 7), vecs[i].exp_word, 20, ok);
            if (ok) n_ok++;
        end
        idle_inputs();
        check("tab_accepted", 40'(n_ok), 40'd8);
        wait_done("tab_done", 30);
        check("tab_count", 40'(count_o), 40'd8);
        check("tab_full", 40'(full_o), 40'd0);
        check_checksum("tab_checksum");

        // Ten random tuples held valid back-to-back
        do_start();
        for (int i = 0; i < 10; i++) begin
            t = rand_tuple();
            send_tuple(t, (i == 9), model_encode(t), 20, ok);
        end
        idle_inputs();
        wait_done("b2b_done", 30);
        check("b2b_writes", 40'(writes), 40'd10);
        check("b2b_no_gaps", 40'(last_wr_cycle - first_wr_cycle), 40'd9);
        check("b2b_last_addr", 40'(last_wr_addr), 40'd9);
        check_checksum("b2b_checksum");

        // Capacity limit: offer 300 tuples to a 256-word memory
        do_start();
        n_ok = 0;
        for (int i = 0; i < 300; i++) begin
            t = rand_tuple();
            send_tuple(t, 1'b0, model_encode(t), 4, ok);
            if (ok) n_ok++;
        end
        wait_done("cap_done", 20);
        repeat (3) @(posedge clk);
        #1;
        check("cap_accepted", 40'(n_ok), 40'd256);
        check("cap_writes", 40'(writes), 40'd256);
        check("cap_last_addr", 40'(last_wr_addr), 40'd255);
        check("cap_count", 40'(count_o), 40'd256);
        check("cap_full", 40'(full_o), 40'd1);
        check("cap_done_level", 40'(done_o), 40'd1);
        check("cap_in_ready", 40'(in_ready_o), 40'd0);
        check_checksum("cap_checksum");
        idle_inputs();

        // Reset while words are still in flight
        do_start();
        for (int i = 0; i < 3; i++) begin
            t = rand_tuple();
            send_tuple(t, 1'b0, model_encode(t), 20, ok);
        end
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_reset_values("midrst");
        do_start();
        t = vecs[1].t;
        send_tuple(t, 1'b1, vecs[1].exp_word, 20, ok);
        idle_inputs();
        wait_done("midrst_done", 20);
        check("midrst_count", 40'(count_o), 40'd1);
        check("midrst_addr", 40'(last_wr_addr), 40'd0);
        check_checksum("midrst_checksum");

        // Every expected write must have been observed
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 40'(exp_q.size()), 40'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
